cic_decim_var: RTL and testbench
================================

CIC_DECIM_VAR -- requirements
Module: cic_decim_var

Interface
REQ-001 SHALL have parameter DATA_WIDTH_I, default 16, meaning per-channel input sample width (signed).
REQ-002 SHALL have parameter DATA_WIDTH_O, default 16, meaning per-channel output sample width (signed).
REQ-003 SHALL have parameter ORDER, default 4, meaning the number of integrator stages and the number of comb stages (range 1..6).
REQ-004 SHALL have parameter MAX_DECIM, default 1024, meaning the largest decimation ratio supported.
REQ-005 SHALL have parameter NUM_CH, default 2, meaning the number of parallel channels sharing one timing/control path.
REQ-006 SHALL derive REG_WIDTH = DATA_WIDTH_I + ORDER*clog2(MAX_DECIM), DW = clog2(MAX_DECIM+1), SW = clog2(REG_WIDTH).
REQ-007 SHALL have clk  in  1  the clock; all logic is rising-edge.
REQ-008 SHALL have arst_n  in  1  the reset: asynchronous, active-low.
REQ-009 SHALL have in_valid  in  1  marking an input sample on all channels this cycle.
REQ-010 SHALL have in_data  in  NUM_CH*DATA_WIDTH_I  channel c at bits [c*DATA_WIDTH_I +: DATA_WIDTH_I].
REQ-011 SHALL have cfg_decim  in  DW  requested decimation ratio; cfg_shift  in  SW  output right-shift; cfg_load  in  1  single-cycle latch/flush pulse.
REQ-012 SHALL have out_valid  out  1  single-cycle output strobe; out_data  out  NUM_CH*DATA_WIDTH_O  packed like in_data; overflow  out  1  sticky saturation flag.

Function
REQ-013 SHALL latch cfg_decim into decim_r on cfg_load, clamping values below 2 to 2 and above MAX_DECIM to MAX_DECIM; cfg_shift latched into shift_r likewise, clamped to REG_WIDTH-1.
REQ-014 SHALL, on the cfg_load cycle, synchronously clear all integrators, combs, the capture registers, the sample counter, the valid pipeline, and overflow; in_valid on that cycle is discarded.
REQ-015 SHALL update every integrator stage only when in_valid=1: stage 1 += sign-extended input, stage k += stage k-1 (registered cascade), wrapping modulo 2^REG_WIDTH.
REQ-016 SHALL count accepted samples only (in_valid=1); when the counter equals decim_r-1 with in_valid=1, SHALL reset the counter to 0 and load each channel's last-integrator value into its capture register (edge E0).
REQ-017 SHALL run ORDER registered comb stages (y = x - x_prev, modulo 2^REG_WIDTH) advancing only on their stage-valid, comb stage k updating at edge Ek.
REQ-018 SHALL form the output at edge E(ORDER+1): arithmetic right shift by shift_r with round-half-up (add 2^(shift_r-1) when shift_r>0), then saturate to [-2^(DATA_WIDTH_O-1), 2^(DATA_WIDTH_O-1)-1].
REQ-019 SHALL pulse out_valid high for exactly the one cycle following E(ORDER+1); out_data SHALL hold its value until the next out_valid.
REQ-020 SHALL set overflow when any channel saturates and hold it until cfg_load or reset.
REQ-021 SHALL sustain in_valid every cycle at decim_r=2 without losing or merging outputs (comb path fully pipelined).
REQ-022 SHALL process all channels identically and independently, with identical timing.

Reset
REQ-023 SHALL, on arst_n low, clear integrators, combs, capture registers, counter, valid pipeline, out_valid, out_data, and overflow; SHALL set decim_r=8, shift_r=ORDER*3.
REQ-024 SHALL produce no out_valid until decim_r new valid samples are accepted after reset or cfg_load.

Structure
REQ-025 SHALL place REG_WIDTH, DW, SW derivation functions and the clamp limits in shared package cic_pkg.
REQ-026 SHALL instantiate NUM_CH copies of sub-module cic_chan (integrators, capture, combs, shift/round/saturate); counter, config registers, valid pipeline, and the overflow OR stay in the top.

Verification
REQ-027 SHALL test DC gain: ORDER=4, cfg_decim=8, cfg_shift=12, in_data ch0=+1000 ch1=-1000, in_valid every cycle -> from the 5th out_valid onward, out ch0=+1000, ch1=-1000, overflow=0.
REQ-028 SHALL test saturation: cfg_decim=8, cfg_shift=10, ch0=+32767, ch1=-32768 -> settled outputs +32767/-32768, overflow=1 sticky until cfg_load.
REQ-029 SHALL test gapped input: in_valid 1-in-3, cfg_decim=4 -> out_valid once per 12 cycles, values identical to the gap-free run.
REQ-030 SHALL test cfg_load mid-frame: cfg_decim=16 after 5 samples -> no out_valid until 16 post-load samples, ORDER+1 cycles after E0.
REQ-031 SHALL test clamping/rounding: cfg_decim=0 behaves as 2; cfg_decim=2000 behaves as 1024; cfg_shift=1 on an internal value of 3 -> 2.
REQ-032 SHALL test reset mid-operation: arst_n low for 1 cycle during the comb flush -> out_valid=0, out_data=0, decim_r=8, shift_r=12 immediately.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared width derivations and configuration limits for the variable-ratio CIC decimator.
package cic_pkg;

  localparam int DECIM_MIN           = 2;
  localparam int DECIM_RST           = 8;
  localparam int SHIFT_RST_PER_ORDER = 3;

  function automatic int f_reg_width(int data_width_i, int order, int max_decim);
    return data_width_i + order * $clog2(max_decim);
  endfunction

  function automatic int f_dw(int max_decim);
    return $clog2(max_decim + 1);
  endfunction

  function automatic int f_sw(int reg_width);
    return $clog2(reg_width);
  endfunction

  function automatic int f_clamp(int value, int lo, int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/cic_chan.sv
// One CIC channel: integrator cascade, decimation capture, comb pipeline and
// shift/round/saturate output stage. Timing strobes come from the shared control path.
module cic_chan
  import cic_pkg::*;
#(
  parameter int DATA_WIDTH_I = 16,
  parameter int DATA_WIDTH_O = 16,
  parameter int ORDER        = 4,
  parameter int REG_WIDTH    = 56,
  parameter int SW           = 6
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    i_clr,
  input  logic                    i_in_valid,
  input  logic [DATA_WIDTH_I-1:0] i_data,
  input  logic                    i_cap,
  input  logic [ORDER:0]          i_stage_vld,
  input  logic [SW-1:0]           i_shift,
  output logic [DATA_WIDTH_O-1:0] o_data,
  output logic                    o_sat
);

  logic signed [REG_WIDTH-1:0] r_integ [ORDER];
  logic signed [REG_WIDTH-1:0] r_cap;
  logic signed [REG_WIDTH-1:0] r_comb  [ORDER];
  logic signed [REG_WIDTH-1:0] r_dly   [ORDER];
  logic signed [REG_WIDTH-1:0] w_x     [ORDER];
  logic signed [REG_WIDTH-1:0] w_in_ext;
  logic signed [REG_WIDTH:0]   w_ext;
  logic signed [REG_WIDTH:0]   w_rnd;
  logic signed [REG_WIDTH:0]   w_shf;
  logic [REG_WIDTH-DATA_WIDTH_O+1:0] w_hi;
  logic                        w_fit;
  logic [DATA_WIDTH_O-1:0]     w_out;

  assign w_in_ext = {{(REG_WIDTH-DATA_WIDTH_I){i_data[DATA_WIDTH_I-1]}}, i_data};

  always_comb begin
    w_x[0] = r_cap;
    for (int k = 1; k < ORDER; k++) w_x[k] = r_comb[k-1];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= '0;
    end else if (i_in_valid) begin
      r_integ[0] <= r_integ[0] + w_in_ext;
      for (int k = 1; k < ORDER; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cap <= '0;
      for (int k = 0; k < ORDER; k++) begin
        r_comb[k] <= '0;
        r_dly[k]  <= '0;
      end
    end else if (i_clr) begin
      r_cap <= '0;
      for (int k = 0; k < ORDER; k++) begin
        r_comb[k] <= '0;
        r_dly[k]  <= '0;
      end
    end else begin
      if (i_cap) r_cap <= r_integ[ORDER-1];
      // each comb stage advances only when its own strobe arrives
      for (int k = 0; k < ORDER; k++) begin
        if (i_stage_vld[k]) begin
          r_comb[k] <= w_x[k] - r_dly[k];
          r_dly[k]  <= w_x[k];
        end
      end
    end
  end

  // one guard bit keeps the half-LSB rounding add from wrapping
  assign w_ext = {r_comb[ORDER-1][REG_WIDTH-1], r_comb[ORDER-1]};
  assign w_rnd = w_ext + ((i_shift != '0) ? ((REG_WIDTH+1)'(1) << (i_shift - SW'(1))) : '0);
  assign w_shf = w_rnd >>> i_shift;
  assign w_hi  = w_shf[REG_WIDTH:DATA_WIDTH_O-1];
  assign w_fit = (&w_hi) | ~(|w_hi);

  always_comb begin
    w_out = w_shf[DATA_WIDTH_O-1:0];
    if (!w_fit) w_out = w_shf[REG_WIDTH] ? {1'b1, {(DATA_WIDTH_O-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH_O-1){1'b1}}};
  end

  assign o_sat = i_stage_vld[ORDER] & ~w_fit;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                           o_data <= '0;
    else if (i_stage_vld[ORDER] && !i_clr) o_data <= w_out;
  end

endmodule

// File: rtl/cic_decim_var.sv
// Multi-channel CIC decimator with runtime ratio/shift; owns the sample counter,
// config registers, valid pipeline and sticky overflow shared by all channels.
module cic_decim_var
  import cic_pkg::*;
#(
  parameter  int DATA_WIDTH_I = 16,
  parameter  int DATA_WIDTH_O = 16,
  parameter  int ORDER        = 4,
  parameter  int MAX_DECIM    = 1024,
  parameter  int NUM_CH       = 2,
  localparam int REG_WIDTH    = f_reg_width(DATA_WIDTH_I, ORDER, MAX_DECIM),
  localparam int DW           = f_dw(MAX_DECIM),
  localparam int SW           = f_sw(REG_WIDTH)
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           in_valid,
  input  logic [NUM_CH*DATA_WIDTH_I-1:0] in_data,
  input  logic [DW-1:0]                  cfg_decim,
  input  logic [SW-1:0]                  cfg_shift,
  input  logic                           cfg_load,
  output logic                           out_valid,
  output logic [NUM_CH*DATA_WIDTH_O-1:0] out_data,
  output logic                           overflow
);

  logic [DW-1:0]     r_decim;
  logic [SW-1:0]     r_shift;
  logic [DW-1:0]     r_cnt;
  logic [ORDER:0]    r_vld;
  logic              r_out_valid;
  logic              r_ovf;
  logic [DW-1:0]     w_decim_clamp;
  logic [SW-1:0]     w_shift_clamp;
  logic              w_tc;
  logic [NUM_CH-1:0] w_sat;

  assign w_decim_clamp = DW'(f_clamp(int'(cfg_decim), DECIM_MIN, MAX_DECIM));
  assign w_shift_clamp = SW'(f_clamp(int'(cfg_shift), 0, REG_WIDTH - 1));

  // terminal count: the decim_r-th accepted sample triggers capture (E0)
  assign w_tc = in_valid & ~cfg_load & (r_cnt == r_decim - DW'(1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_decim     <= DW'(DECIM_RST);
      r_shift     <= SW'(ORDER * SHIFT_RST_PER_ORDER);
      r_cnt       <= '0;
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (cfg_load) begin
      r_decim     <= w_decim_clamp;
      r_shift     <= w_shift_clamp;
      r_cnt       <= '0;
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (in_valid) r_cnt <= w_tc ? '0 : r_cnt + DW'(1);
      r_vld       <= {r_vld[ORDER-1:0], w_tc};
      r_out_valid <= r_vld[ORDER];
      if (|w_sat) r_ovf <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign overflow  = r_ovf;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    cic_chan #(
      .DATA_WIDTH_I (DATA_WIDTH_I),
      .DATA_WIDTH_O (DATA_WIDTH_O),
      .ORDER        (ORDER),
      .REG_WIDTH    (REG_WIDTH),
      .SW           (SW)
    ) u_chan (
      .clk         (clk),
      .arst_n      (arst_n),
      .i_clr       (cfg_load),
      .i_in_valid  (in_valid),
      .i_data      (in_data[c*DATA_WIDTH_I +: DATA_WIDTH_I]),
      .i_cap       (w_tc),
      .i_stage_vld (r_vld),
      .i_shift     (r_shift),
      .o_data      (out_data[c*DATA_WIDTH_O +: DATA_WIDTH_O]),
      .o_sat       (w_sat[c])
    );
  end

endmodule

// File: tb/tb_cic_decim_var.sv
// Scoreboard bench for cic_decim_var: a difference-equation reference model queues
// expected outputs; a negedge monitor compares data, overflow and arrival cycle.
module tb_cic_decim_var;

  localparam int DWI  = 16;
  localparam int DWO  = 16;
  localparam int ORD  = 4;
  localparam int MAXD = 1024;
  localparam int NCH  = 2;
  localparam int RW   = DWI + ORD * 10;
  localparam int DW   = 11;
  localparam int SW   = 6;

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [NCH*DWI-1:0]   in_data = '0;
  logic [DW-1:0]        cfg_decim = '0;
  logic [SW-1:0]        cfg_shift = '0;
  logic                 cfg_load = 1'b0;
  logic                 out_valid;
  logic [NCH*DWO-1:0]   out_data;
  logic                 overflow;

  cic_decim_var #(
    .DATA_WIDTH_I (DWI),
    .DATA_WIDTH_O (DWO),
    .ORDER        (ORD),
    .MAX_DECIM    (MAXD),
    .NUM_CH       (NCH)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_decim (cfg_decim),
    .cfg_shift (cfg_shift),
    .cfg_load  (cfg_load),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    longint d0;
    longint d1;
    bit     ovf;
    longint cyc;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  longint m_int  [NCH][ORD];
  longint m_hist [NCH][ORD+1];
  int     m_cnt, m_decim, m_shift;
  bit     m_ovf;
  bit     gap_chk = 1'b0;
  longint gap_last = -1;

  task automatic chk(string nm, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint wrap(longint x);
    return (x <<< (64 - RW)) >>> (64 - RW);
  endfunction

  function automatic longint binom(int n, int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  task automatic model_reset(int dec, int sh);
    m_decim = (dec < 2) ? 2 : (dec > MAXD) ? MAXD : dec;
    m_shift = (sh > RW - 1) ? RW - 1 : sh;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < ORD; k++) m_int[c][k] = 0;
      for (int k = 0; k <= ORD; k++) m_hist[c][k] = 0;
    end
  endtask

  // Output = ORDER-th backward difference of the decimated last-integrator samples.
  task automatic model_sample(longint d0, longint d1, longint e0_cyc);
    exp_t   e;
    longint y;
    longint din [NCH];
    bit     sat_any;
    din[0]  = d0;
    din[1]  = d1;
    sat_any = 1'b0;
    if (m_cnt == m_decim - 1) begin
      m_cnt = 0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = ORD; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = m_int[c][ORD-1];
        y = 0;
        for (int k = 0; k <= ORD; k++)
          y += ((k % 2) ? -binom(ORD, k) : binom(ORD, k)) * m_hist[c][k];
        y = wrap(y);
        if (m_shift > 0) y += longint'(1) <<< (m_shift - 1);
        y = y >>> m_shift;
        if (y > 32767) begin
          y = 32767;
          sat_any = 1'b1;
        end else if (y < -32768) begin
          y = -32768;
          sat_any = 1'b1;
        end
        if (c == 0) e.d0 = y;
        else        e.d1 = y;
      end
      m_ovf = m_ovf | sat_any;
      e.ovf = m_ovf;
      e.cyc = e0_cyc + ORD + 1;
      q.push_back(e);
    end else begin
      m_cnt++;
    end
    for (int c = 0; c < NCH; c++) begin
      for (int k = ORD - 1; k > 0; k--) m_int[c][k] = wrap(m_int[c][k] + m_int[c][k-1]);
      m_int[c][0] = wrap(m_int[c][0] + din[c]);
    end
  endtask

  task automatic step(bit v, int d0, int d1);
    in_valid = v;
    in_data  = {16'(d1), 16'(d0)};
    cfg_load = 1'b0;
    if (v) model_sample(longint'(d0), longint'(d1), cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (8) step(1'b0, 0, 0);
    chk("drain_queue_empty", longint'(q.size()), 0);
  endtask

  task automatic load(int dec, int sh, bit do_drain);
    if (do_drain) drain();
    cfg_decim = DW'(dec);
    cfg_shift = SW'(sh);
    cfg_load  = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    in_data   = $urandom;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    q.delete();
    model_reset(dec, sh);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  always @(negedge clk) begin
    if (arst_n && out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("out_ch0", longint'($signed(out_data[DWO-1:0])), mon_e.d0);
        chk("out_ch1", longint'($signed(out_data[2*DWO-1:DWO])), mon_e.d1);
        chk("overflow", longint'(overflow), longint'(mon_e.ovf));
        chk("latency", cyc, mon_e.cyc);
        if (gap_chk) begin
          if (gap_last >= 0) chk("gap_period", cyc - gap_last, 12);
          gap_last = cyc;
        end
      end
    end
  end

  initial begin
    int dec, sh, dens;
    model_reset(8, 12);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_overflow", longint'(overflow), 0);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // DC gain: 8^4 = 2^12, shift 12 gives unity
    load(8, 12, 1'b0);
    repeat (80) step(1'b1, 1000, -1000);
    drain();
    chk("dc_ch0", longint'($signed(out_data[15:0])), 1000);
    chk("dc_ch1", longint'($signed(out_data[31:16])), -1000);
    chk("dc_overflow", longint'(overflow), 0);

    // saturation and sticky overflow
    load(8, 10, 1'b1);
    repeat (80) step(1'b1, 32767, -32768);
    drain();
    chk("sat_ch0", longint'($signed(out_data[15:0])), 32767);
    chk("sat_ch1", longint'($signed(out_data[31:16])), -32768);
    chk("sat_overflow", longint'(overflow), 1);
    repeat (40) step(1'b1, 0, 0);
    chk("sat_overflow_sticky", longint'(overflow), 1);
    load(8, 12, 1'b1);
    chk("ovf_cleared_by_load", longint'(overflow), 0);

    // gapped input: one valid in three, ratio 4
    load(4, 8, 1'b1);
    gap_last = -1;
    gap_chk  = 1'b1;
    for (int i = 0; i < 72; i++) step(i % 3 == 0, 500, -500);
    repeat (8) step(1'b0, 0, 0);
    gap_chk = 1'b0;
    chk("gap_ch0", longint'($signed(out_data[15:0])), 500);

    // reload mid-frame, then 16 fresh samples before any output
    load(8, 12, 1'b1);
    repeat (5) step(1'b1, rnd16(), rnd16());
    load(16, 16, 1'b0);
    for (int i = 0; i < 80; i++) step(1'b1, rnd16(), rnd16());

    // clamping and rounding
    load(0, 4, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, rnd16(), rnd16());
    load(2000, 40, 1'b1);
    for (int i = 0; i < 3 * 1024 + 10; i++)
      step(1'b1, int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
    load(3, 1, 1'b1);
    repeat (30) step(1'b1, 1, -1);
    drain();
    chk("round_ch0", longint'($signed(out_data[15:0])), 41);
    chk("round_ch1", longint'($signed(out_data[31:16])), -40);
    load(5, 63, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, rnd16(), rnd16());

    // randomized configurations and valid densities
    for (int p = 0; p < 6; p++) begin
      dec  = int'($urandom_range(0, 12));
      sh   = int'($urandom_range(0, 63));
      dens = int'($urandom_range(30, 100));
      load(dec, sh, 1'b1);
      for (int i = 0; i < 150; i++)
        step(int'($urandom_range(1, 100)) <= dens, rnd16(), rnd16());
    end

    // async reset while the comb pipeline is flushing
    load(4, 8, 1'b1);
    repeat (8) step(1'b1, 500, -500);
    repeat (2) step(1'b0, 0, 0);
    arst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", longint'(out_valid), 0);
    chk("rst_mid_out_data", longint'(out_data), 0);
    chk("rst_mid_overflow", longint'(overflow), 0);
    q.delete();
    model_reset(8, 12);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (48) step(1'b1, 1000, -1000);
    drain();
    chk("post_rst_default_ch0", longint'($signed(out_data[15:0])), 1000);
    chk("post_rst_default_ch1", longint'($signed(out_data[31:16])), -1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
